// File: rtl/seq_chunk_adder_if.sv
// seq_chunk_adder_if: Start/Busy/Done handshake bundle for seq_chunk_adder.
// master drives the request, slave is the adder.
interface seq_chunk_adder_if #(
   parameter int WIDTH = 8
);
   logic             Start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic             Sub;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] S;
   logic             Cout;
   logic             V;

   modport master (
      output Start, A, B, Cin, Sub,
      input  Busy, Done, S, Cout, V
   );

   modport slave (
      input  Start, A, B, Cin, Sub,
      output Busy, Done, S, Cout, V
   );
endinterface

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: WIDTH-bit add/sub, CHUNK bits per clock, carry held in a register.
// Define SEQ_CHUNK_ADDER_OVF_EN to compute the signed overflow flag V.
module seq_chunk_adder #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   seq_chunk_adder_if.slave bus
);
   localparam int N  = WIDTH / CHUNK;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] s_q;
   logic [IW-1:0]    idx;
   logic             carry;
   logic             busy_q;
   logic             done_q;
   logic             cout_q;
   logic [CHUNK:0]   sum;
   logic             last;

   // operands shift right so the live chunk is always the low CHUNK bits
   always_comb begin
      sum = {1'b0, a_q[CHUNK-1:0]}
          + {1'b0, b_q[CHUNK-1:0]}
          + {{CHUNK{1'b0}}, carry};
   end

   assign last = (idx == LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         a_q    <= '0;
         b_q    <= '0;
         s_q    <= '0;
         idx    <= '0;
         carry  <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         cout_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            IDLE, DONE: begin
               if (bus.Start) begin
                  a_q    <= bus.A;
                  b_q    <= bus.Sub ? ~bus.B : bus.B;
                  carry  <= bus.Sub ? ~bus.Cin : bus.Cin;
                  idx    <= '0;
                  busy_q <= 1'b1;
                  state  <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               s_q[idx*CHUNK +: CHUNK] <= sum[CHUNK-1:0];
               carry <= sum[CHUNK];
               a_q   <= a_q >> CHUNK;
               b_q   <= b_q >> CHUNK;
               if (last) begin
                  cout_q <= sum[CHUNK];
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= DONE;
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            default: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

`ifdef SEQ_CHUNK_ADDER_OVF_EN
   logic v_q;
   logic c_msb;

   // carry into the MSB recovered from the MSB sum bit, no second adder
   assign c_msb = sum[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         v_q <= 1'b0;
      end else if (state == RUN && last) begin
         v_q <= c_msb ^ sum[CHUNK];
      end
   end

   assign bus.V = v_q;
`else
   assign bus.V = 1'b0;
`endif

   assign bus.Busy = busy_q;
   assign bus.Done = done_q;
   assign bus.S    = s_q;
   assign bus.Cout = cout_q;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb_seq_chunk_adder: vectors, handshake corners and random ops vs an arithmetic model.
// Covers WIDTH=8/CHUNK=4 and WIDTH=16/CHUNK=1 instances.
module tb_seq_chunk_adder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_chunk_adder_if #(.WIDTH(8))  b8 ();
   seq_chunk_adder_if #(.WIDTH(16)) b16 ();

   seq_chunk_adder #(.WIDTH(8), .CHUNK(4)) u8 (
      .clk(clk),
      .rst(rst),
      .bus(b8)
   );

   seq_chunk_adder #(.WIDTH(16), .CHUNK(1)) u16 (
      .clk(clk),
      .rst(rst),
      .bus(b16)
   );

`ifdef SEQ_CHUNK_ADDER_OVF_EN
   localparam bit OVF = 1'b1;
`else
   localparam bit OVF = 1'b0;
`endif

   typedef struct packed {
      logic [15:0] s;
      logic        cout;
      logic        v;
   } res_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic       sub;
      logic [7:0] s;
      logic       cout;
      logic       v;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic res_t model(input int w, input longint a, input longint b,
                                  input bit cin, input bit sub);
      longint m;
      longint r;
      bit sa, sb, ss;
      res_t o;
      m = (longint'(1) << w) - 1;
      if (!sub) begin
         r = a + b + longint'(cin);
         o.cout = (r > m);
      end else begin
         r = a - b - longint'(cin);
         o.cout = (a >= b + longint'(cin));
      end
      r = r & m;
      o.s = 16'(r);
      sa = bit'((a >> (w - 1)) & 1);
      sb = bit'((b >> (w - 1)) & 1);
      ss = bit'((r >> (w - 1)) & 1);
      o.v = sub ? (sa != sb && ss != sa) : (sa == sb && ss != sa);
      if (!OVF) o.v = 1'b0;
      return o;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Issue one op, wait (bounded) for Done; returns at the Done cycle's negedge
   task automatic run_op(input bit wide, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub,
                         output res_t got, output int busy_n, output bit done_ok);
      int guard;
      @(negedge clk);
      if (wide) begin
         b16.Start = 1'b1; b16.A = a; b16.B = b; b16.Cin = cin; b16.Sub = sub;
      end else begin
         b8.Start = 1'b1; b8.A = a[7:0]; b8.B = b[7:0]; b8.Cin = cin; b8.Sub = sub;
      end
      @(negedge clk);
      b8.Start = 1'b0;
      b16.Start = 1'b0;
      busy_n = 0;
      guard = 0;
      done_ok = 1'b0;
      while (guard < 40) begin
         if (wide ? b16.Done : b8.Done) begin
            done_ok = 1'b1;
            break;
         end
         if (wide ? b16.Busy : b8.Busy) busy_n++;
         @(negedge clk);
         guard++;
      end
      got.s    = wide ? b16.S : {8'h00, b8.S};
      got.cout = wide ? b16.Cout : b8.Cout;
      got.v    = wide ? b16.V : b8.V;
   endtask

   task automatic op_check(input string name, input bit wide,
                           input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic sub);
      res_t got, exp;
      int busy_n;
      bit done_ok;
      int w;
      w = wide ? 16 : 8;
      exp = model(w, longint'(a), longint'(b), cin, sub);
      run_op(wide, a, b, cin, sub, got, busy_n, done_ok);
      chk({name, " done"}, 32'(done_ok), 32'd1);
      chk({name, " busy_cycles"}, 32'(busy_n), wide ? 32'd16 : 32'd2);
      chk({name, " S"}, 32'(got.s), 32'(exp.s));
      chk({name, " Cout"}, 32'(got.cout), 32'(exp.cout));
      chk({name, " V"}, 32'(got.v), 32'(exp.v));
      @(negedge clk);
      chk({name, " done_pulse"}, wide ? 32'(b16.Done) : 32'(b8.Done), 32'd0);
   endtask

   vec_t tbl [6];

   initial begin
      res_t got;
      int busy_n;
      bit done_ok;

      tbl[0] = '{8'h3C, 8'h55, 1'b0, 1'b0, 8'h91, 1'b0, 1'b1};
      tbl[1] = '{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
      tbl[2] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
      tbl[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
      tbl[4] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
      tbl[5] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};

      b8.Start = 0; b8.A = 0; b8.B = 0; b8.Cin = 0; b8.Sub = 0;
      b16.Start = 0; b16.A = 0; b16.B = 0; b16.Cin = 0; b16.Sub = 0;

      do_reset();
      chk("rst Busy", 32'(b8.Busy), 0);
      chk("rst Done", 32'(b8.Done), 0);
      chk("rst S", 32'(b8.S), 0);
      chk("rst Cout", 32'(b8.Cout), 0);
      chk("rst V", 32'(b8.V), 0);
      chk("rst Busy16", 32'(b16.Busy), 0);

      for (int i = 0; i < 6; i++) begin
         run_op(1'b0, {8'h00, tbl[i].a}, {8'h00, tbl[i].b}, tbl[i].cin, tbl[i].sub,
                got, busy_n, done_ok);
         chk($sformatf("vec%0d done", i), 32'(done_ok), 1);
         chk($sformatf("vec%0d busy", i), 32'(busy_n), 2);
         chk($sformatf("vec%0d S", i), 32'(got.s), 32'(tbl[i].s));
         chk($sformatf("vec%0d Cout", i), 32'(got.cout), 32'(tbl[i].cout));
         chk($sformatf("vec%0d V", i), 32'(got.v), 32'(tbl[i].v & OVF));
      end

      // Start while Busy is ignored; Start in the Done cycle is accepted
      @(negedge clk);
      b8.Start = 1; b8.A = 8'h01; b8.B = 8'h01; b8.Cin = 0; b8.Sub = 0;
      @(negedge clk);
      chk("ign busy1", 32'(b8.Busy), 1);
      chk("ign done1", 32'(b8.Done), 0);
      b8.A = 8'h11; b8.B = 8'h22;
      @(negedge clk);
      b8.Start = 0;
      chk("ign done2", 32'(b8.Done), 0);
      @(negedge clk);
      chk("ign done3", 32'(b8.Done), 1);
      chk("ign S", 32'(b8.S), 32'h02);
      b8.Start = 1; b8.A = 8'h11; b8.B = 8'h22;
      @(negedge clk);
      b8.Start = 0;
      chk("b2b busy", 32'(b8.Busy), 1);
      chk("b2b done", 32'(b8.Done), 0);
      @(negedge clk);
      chk("b2b done mid", 32'(b8.Done), 0);
      @(negedge clk);
      chk("b2b done", 32'(b8.Done), 1);
      chk("b2b S", 32'(b8.S), 32'h33);
      @(negedge clk);
      chk("b2b done drop", 32'(b8.Done), 0);

      // rst one cycle after Start aborts with no Done
      b8.Start = 1; b8.A = 8'h3C; b8.B = 8'h55;
      @(negedge clk);
      b8.Start = 0;
      rst = 1;
      @(negedge clk);
      rst = 0;
      chk("abort Busy", 32'(b8.Busy), 0);
      chk("abort Done", 32'(b8.Done), 0);
      chk("abort S", 32'(b8.S), 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("abort nodone%0d", i), 32'(b8.Done), 0);
      end

      // rst and Start together: rst wins
      op_check("pre", 1'b0, 16'h0003, 16'h0004, 1'b0, 1'b0);
      b8.Start = 1; b8.A = 8'h10; b8.B = 8'h20;
      rst = 1;
      @(negedge clk);
      rst = 0;
      b8.Start = 0;
      chk("rstwin Busy", 32'(b8.Busy), 0);
      chk("rstwin S", 32'(b8.S), 0);
      @(negedge clk);
      chk("rstwin Busy2", 32'(b8.Busy), 0);
      chk("rstwin Done", 32'(b8.Done), 0);

      op_check("w16 ffff+1", 1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
      op_check("w16 8000-1", 1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1);

      for (int i = 0; i < 150; i++) begin
         op_check($sformatf("rnd8_%0d", i), 1'b0, 16'($urandom_range(0, 255)),
                  16'($urandom_range(0, 255)), 1'($urandom), 1'($urandom));
      end
      for (int i = 0; i < 30; i++) begin
         op_check($sformatf("rnd16_%0d", i), 1'b1, 16'($urandom),
                  16'($urandom), 1'($urandom), 1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
